// File: rtl/pulse_cfg_pkg.sv
// Shared configuration constants for the pulses core: register address map,
// per-address frame lengths and widths, and power-on parameter defaults.
package pulse_cfg_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_DATA = 1'b1} state_t;

  localparam logic [7:0] ADDR_PER      = 8'h00;
  localparam logic [7:0] ADDR_P1WID    = 8'h01;
  localparam logic [7:0] ADDR_DEL      = 8'h02;
  localparam logic [7:0] ADDR_P2WID    = 8'h03;
  localparam logic [7:0] ADDR_NUTD     = 8'h04;
  localparam logic [7:0] ADDR_NUTW     = 8'h05;
  localparam logic [7:0] ADDR_BL       = 8'h06;
  localparam logic [7:0] ADDR_PBL      = 8'h07;
  localparam logic [7:0] ADDR_PBLOFF   = 8'h08;
  localparam logic [7:0] ADDR_CP       = 8'h09;
  localparam logic [7:0] ADDR_APPLY    = 8'hFF;

  localparam logic [31:0] CFG_DEF_PER    = 32'h0004_0000;
  localparam logic [15:0] CFG_DEF_P1WID  = 16'd30;
  localparam logic [15:0] CFG_DEF_P2WID  = 16'd60;
  localparam logic [15:0] CFG_DEF_DEL    = 16'd200;
  localparam logic [7:0]  CFG_DEF_CP     = 8'd3;
  localparam logic [7:0]  CFG_DEF_PBL    = 8'd50;
  localparam logic [15:0] CFG_DEF_PBLOFF = 16'd100;
  localparam logic [7:0]  CFG_DEF_NUTW   = 8'd100;
  localparam logic [15:0] CFG_DEF_NUTD   = 16'd100;

  function automatic logic addr_valid(input logic [7:0] a);
    return (a <= ADDR_CP);
  endfunction

  function automatic logic [2:0] addr_nbytes(input logic [7:0] a);
    case (a)
      ADDR_PER:                                      return 3'd4;
      ADDR_P1WID, ADDR_DEL, ADDR_P2WID, ADDR_NUTD,
      ADDR_PBLOFF:                                   return 3'd2;
      ADDR_NUTW, ADDR_BL, ADDR_PBL, ADDR_CP:         return 3'd1;
      default:                                       return 3'd0;
    endcase
  endfunction

  function automatic logic [5:0] addr_width(input logic [7:0] a);
    case (a)
      ADDR_PER:                                      return 6'd32;
      ADDR_P1WID, ADDR_DEL, ADDR_P2WID, ADDR_NUTD,
      ADDR_PBLOFF:                                   return 6'd16;
      ADDR_NUTW, ADDR_PBL, ADDR_CP:                  return 6'd8;
      ADDR_BL:                                       return 6'd1;
      default:                                       return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/param_bank.sv
// Staged/live register pairs for the pulse parameters. Writes land in the staged
// copy; the apply strobe copies every staged value to the live outputs at once.
module param_bank
  import pulse_cfg_pkg::*;
#(
  parameter logic [31:0] DEF_PER    = CFG_DEF_PER,
  parameter logic [15:0] DEF_P1WID  = CFG_DEF_P1WID,
  parameter logic [15:0] DEF_P2WID  = CFG_DEF_P2WID,
  parameter logic [15:0] DEF_DEL    = CFG_DEF_DEL,
  parameter logic [7:0]  DEF_CP     = CFG_DEF_CP,
  parameter logic [7:0]  DEF_PBL    = CFG_DEF_PBL,
  parameter logic [15:0] DEF_PBLOFF = CFG_DEF_PBLOFF,
  parameter logic [7:0]  DEF_NUTW   = CFG_DEF_NUTW,
  parameter logic [15:0] DEF_NUTD   = CFG_DEF_NUTD
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr_en,
  input  logic [7:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        apply,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] nut_d,
  output logic [7:0]  nut_w,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl
);

  logic [31:0] st_per;
  logic [15:0] st_p1wid, st_del, st_p2wid, st_nut_d, st_p_bl_off;
  logic [7:0]  st_nut_w, st_cp, st_p_bl;
  logic        st_bl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st_per      <= DEF_PER;
      st_p1wid    <= DEF_P1WID;
      st_del      <= DEF_DEL;
      st_p2wid    <= DEF_P2WID;
      st_nut_d    <= DEF_NUTD;
      st_nut_w    <= DEF_NUTW;
      st_bl       <= 1'b1;
      st_p_bl     <= DEF_PBL;
      st_p_bl_off <= DEF_PBLOFF;
      st_cp       <= DEF_CP;
    end else if (wr_en) begin
      case (wr_addr)
        ADDR_PER:    st_per      <= wr_data;
        ADDR_P1WID:  st_p1wid    <= wr_data[15:0];
        ADDR_DEL:    st_del      <= wr_data[15:0];
        ADDR_P2WID:  st_p2wid    <= wr_data[15:0];
        ADDR_NUTD:   st_nut_d    <= wr_data[15:0];
        ADDR_NUTW:   st_nut_w    <= wr_data[7:0];
        ADDR_BL:     st_bl       <= wr_data[0];
        ADDR_PBL:    st_p_bl     <= wr_data[7:0];
        ADDR_PBLOFF: st_p_bl_off <= wr_data[15:0];
        ADDR_CP:     st_cp       <= wr_data[7:0];
        default: ;
      endcase
    end
  end

  // Live copy reads the staged values from before this edge, so a commit
  // landing in the apply cycle waits for the following apply.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      per      <= DEF_PER;
      p1wid    <= DEF_P1WID;
      del      <= DEF_DEL;
      p2wid    <= DEF_P2WID;
      nut_d    <= DEF_NUTD;
      nut_w    <= DEF_NUTW;
      bl       <= 1'b1;
      p_bl     <= DEF_PBL;
      p_bl_off <= DEF_PBLOFF;
      cp       <= DEF_CP;
    end else if (apply) begin
      per      <= st_per;
      p1wid    <= st_p1wid;
      del      <= st_del;
      p2wid    <= st_p2wid;
      nut_d    <= st_nut_d;
      nut_w    <= st_nut_w;
      bl       <= st_bl;
      p_bl     <= st_p_bl;
      p_bl_off <= st_p_bl_off;
      cp       <= st_cp;
    end
  end

endmodule

// File: rtl/pulse_param_loader.sv
// UART byte-stream frame parser for the pulses core; stages writes and makes
// them live only at a pulse-period boundary after an apply command.
module pulse_param_loader
  import pulse_cfg_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 120000,
  parameter logic [31:0] DEF_PER     = CFG_DEF_PER,
  parameter logic [15:0] DEF_P1WID   = CFG_DEF_P1WID,
  parameter logic [15:0] DEF_P2WID   = CFG_DEF_P2WID,
  parameter logic [15:0] DEF_DEL     = CFG_DEF_DEL,
  parameter logic [7:0]  DEF_CP      = CFG_DEF_CP,
  parameter logic [7:0]  DEF_PBL     = CFG_DEF_PBL,
  parameter logic [15:0] DEF_PBLOFF  = CFG_DEF_PBLOFF,
  parameter logic [7:0]  DEF_NUTW    = CFG_DEF_NUTW,
  parameter logic [15:0] DEF_NUTD    = CFG_DEF_NUTD
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        cyc_start,
  output logic [31:0] per,
  output logic [15:0] p1wid,
  output logic [15:0] del,
  output logic [15:0] p2wid,
  output logic [15:0] nut_d,
  output logic [7:0]  nut_w,
  output logic [7:0]  cp,
  output logic [7:0]  p_bl,
  output logic [15:0] p_bl_off,
  output logic        bl,
  output logic        rxd,
  output logic        err,
  output logic        busy
);

  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  state_t             state_q, state_d;
  logic [2:0]         cnt_q;
  logic [7:0]         addr_q;
  logic [31:0]        asm_q;
  logic [GAP_W-1:0]   gap_q;
  logic               wr_en_q, apply_pend_q;
  logic               load_addr, shift_byte, last_byte, bad_addr, apply_req, timeout;
  logic               apply;
  logic [5:0]         wr_w;
  logic [31:0]        wr_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load_addr) state_d = ST_DATA;
      ST_DATA: if (last_byte || timeout) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_addr  = 1'b0;
    apply_req  = 1'b0;
    bad_addr   = 1'b0;
    shift_byte = 1'b0;
    last_byte  = 1'b0;
    timeout    = 1'b0;
    if (state_q == ST_IDLE) begin
      load_addr = rx_valid && addr_valid(rx_data);
      apply_req = rx_valid && (rx_data == ADDR_APPLY);
      bad_addr  = rx_valid && !addr_valid(rx_data) && (rx_data != ADDR_APPLY);
    end else begin
      shift_byte = rx_valid;
      last_byte  = rx_valid && (cnt_q == 3'd1);
      timeout    = !rx_valid && (gap_q == GAP_W'(TIMEOUT_CYC - 1));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      asm_q   <= '0;
      gap_q   <= '0;
      wr_en_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      if (load_addr) begin
        addr_q <= rx_data;
        cnt_q  <= addr_nbytes(rx_data);
      end else if (shift_byte) begin
        asm_q <= {asm_q[23:0], rx_data};
        cnt_q <= cnt_q - 3'd1;
      end
      if (rx_valid || state_q != ST_DATA) gap_q <= '0;
      else                                gap_q <= gap_q + 1'b1;
      wr_en_q <= last_byte;
      err     <= bad_addr || timeout;
    end
  end

  // A pending apply is consumed only by a cyc_start arriving after the FF byte
  // has registered; extra FF bytes while pending are absorbed.
  assign apply = cyc_start && apply_pend_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      apply_pend_q <= 1'b0;
      rxd          <= 1'b0;
    end else begin
      if (apply)          apply_pend_q <= 1'b0;
      else if (apply_req) apply_pend_q <= 1'b1;
      rxd <= apply;
    end
  end

  assign busy    = (state_q == ST_DATA) || apply_pend_q;
  assign wr_w    = addr_width(addr_q);
  assign wr_data = (wr_w >= 6'd32) ? asm_q : (asm_q & ((32'd1 << wr_w) - 32'd1));

  param_bank #(
    .DEF_PER(DEF_PER), .DEF_P1WID(DEF_P1WID), .DEF_P2WID(DEF_P2WID),
    .DEF_DEL(DEF_DEL), .DEF_CP(DEF_CP), .DEF_PBL(DEF_PBL),
    .DEF_PBLOFF(DEF_PBLOFF), .DEF_NUTW(DEF_NUTW), .DEF_NUTD(DEF_NUTD)
  ) u_bank (
    .clk(clk), .resetn(resetn),
    .wr_en(wr_en_q), .wr_addr(addr_q), .wr_data(wr_data), .apply(apply),
    .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid), .nut_d(nut_d),
    .nut_w(nut_w), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off), .bl(bl)
  );

endmodule

// File: tb/tb_pulse_param_loader.sv
// Scoreboard bench for pulse_param_loader: expected live sets are queued on each
// modelled apply and compared when rxd strobes.
module tb_pulse_param_loader;

  localparam int TO = 200;

  typedef struct {
    logic [31:0] per;
    logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
    logic [7:0]  nut_w, cp, p_bl;
    logic        bl;
  } cfg_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        cyc_start = 1'b0;
  logic [31:0] per;
  logic [15:0] p1wid, del, p2wid, nut_d, p_bl_off;
  logic [7:0]  nut_w, cp, p_bl;
  logic        bl, rxd, err, busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  = 0;
  int   rxd_cnt  = 0;
  int   exp_rxd  = 0;
  cfg_t m_stg;
  logic m_pend;
  cfg_t exp_q[$];

  pulse_param_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .cyc_start(cyc_start), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
    .nut_d(nut_d), .nut_w(nut_w), .cp(cp), .p_bl(p_bl), .p_bl_off(p_bl_off),
    .bl(bl), .rxd(rxd), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic cfg_t defaults();
    cfg_t c;
    c.per = 32'h0004_0000; c.p1wid = 16'd30; c.del = 16'd200; c.p2wid = 16'd60;
    c.nut_d = 16'd100; c.nut_w = 8'd100; c.bl = 1'b1; c.p_bl = 8'd50;
    c.p_bl_off = 16'd100; c.cp = 8'd3;
    return c;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (err) err_cnt++;
      if (rxd) begin
        cfg_t e;
        rxd_cnt++;
        if (exp_q.size() == 0) check_eq("rxd_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          check_eq("per", per, e.per);
          check_eq("p1wid", {16'd0, p1wid}, {16'd0, e.p1wid});
          check_eq("del", {16'd0, del}, {16'd0, e.del});
          check_eq("p2wid", {16'd0, p2wid}, {16'd0, e.p2wid});
          check_eq("nut_d", {16'd0, nut_d}, {16'd0, e.nut_d});
          check_eq("nut_w", {24'd0, nut_w}, {24'd0, e.nut_w});
          check_eq("bl", {31'd0, bl}, {31'd0, e.bl});
          check_eq("p_bl", {24'd0, p_bl}, {24'd0, e.p_bl});
          check_eq("p_bl_off", {16'd0, p_bl_off}, {16'd0, e.p_bl_off});
          check_eq("cp", {24'd0, cp}, {24'd0, e.cp});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input int n, input logic [31:0] v);
    send_byte(a);
    for (int i = n - 1; i >= 0; i--) send_byte(v[8*i +: 8]);
    case (a)
      8'h00: m_stg.per = v;
      8'h01: m_stg.p1wid = v[15:0];
      8'h02: m_stg.del = v[15:0];
      8'h03: m_stg.p2wid = v[15:0];
      8'h04: m_stg.nut_d = v[15:0];
      8'h05: m_stg.nut_w = v[7:0];
      8'h06: m_stg.bl = v[0];
      8'h07: m_stg.p_bl = v[7:0];
      8'h08: m_stg.p_bl_off = v[15:0];
      8'h09: m_stg.cp = v[7:0];
      default: ;
    endcase
  endtask

  task automatic send_apply();
    send_byte(8'hFF);
    m_pend = 1'b1;
  endtask

  task automatic do_cyc();
    if (m_pend) begin
      exp_q.push_back(m_stg);
      exp_rxd++;
      m_pend = 1'b0;
    end
    @(posedge clk); #1;
    cyc_start = 1'b1;
    @(posedge clk); #1;
    cyc_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    m_stg = defaults();
    m_pend = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int e0, r0, w;
    m_stg = defaults();
    m_pend = 1'b0;
    do_reset();

    // 1. reset state
    check_eq("rst_per", per, 32'h0004_0000);
    check_eq("rst_p1wid", {16'd0, p1wid}, 32'd30);
    check_eq("rst_del", {16'd0, del}, 32'd200);
    check_eq("rst_p2wid", {16'd0, p2wid}, 32'd60);
    check_eq("rst_cp", {24'd0, cp}, 32'd3);
    check_eq("rst_bl", {31'd0, bl}, 32'd1);
    check_eq("rst_strobes", {29'd0, rxd, err, busy}, 32'd0);

    // 2. staged only, then applied
    send_frame(8'h01, 2, 32'd100);
    do_cyc(); do_cyc();
    check_eq("p1wid_no_apply", {16'd0, p1wid}, 32'd30);
    send_apply();
    check_eq("busy_pending", {31'd0, busy}, 32'd1);
    do_cyc();
    check_eq("p1wid_applied", {16'd0, p1wid}, 32'd100);

    // 3. 32-bit write, repeated FF gives a single apply
    send_frame(8'h00, 4, 32'h1234_5678);
    send_apply(); send_apply();
    do_cyc();
    check_eq("busy_after_apply", {31'd0, busy}, 32'd0);
    r0 = rxd_cnt;
    do_cyc();
    check_eq("single_apply", rxd_cnt - r0, 32'd0);

    // 4. bad address
    e0 = err_cnt;
    send_byte(8'h0A);
    repeat (2) @(posedge clk); #1;
    check_eq("bad_addr_err", err_cnt - e0, 32'd1);
    check_eq("bad_addr_idle", {31'd0, busy}, 32'd0);
    send_frame(8'h09, 1, 32'd5);
    send_apply(); do_cyc();
    check_eq("cp_applied", {24'd0, cp}, 32'd5);

    // 5. inter-byte timeout discards the partial frame
    e0 = err_cnt;
    send_byte(8'h02); send_byte(8'h01);
    w = 0;
    while (err_cnt == e0 && w < TO + 50) begin @(posedge clk); w++; end
    @(posedge clk); #1;
    check_eq("timeout_err", err_cnt - e0, 32'd1);
    check_eq("timeout_idle", {31'd0, busy}, 32'd0);
    send_apply(); do_cyc();
    check_eq("del_kept", {16'd0, del}, 32'd200);

    // 6. reset mid-frame, then FF coincident with cyc_start
    send_byte(8'h04); send_byte(8'h00);
    #2 resetn = 1'b0;
    #1 check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("async_rst_per", per, 32'h0004_0000);
    do_reset();
    send_frame(8'h04, 2, 32'd7);
    send_frame(8'h05, 1, 32'd9);
    send_frame(8'h08, 2, 32'h0123);
    send_frame(8'h06, 1, 32'd0);
    @(posedge clk); #1;
    r0 = rxd_cnt;
    rx_data = 8'hFF; rx_valid = 1'b1; cyc_start = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; cyc_start = 1'b0;
    m_pend = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_eq("same_cycle_no_apply", rxd_cnt - r0, 32'd0);
    check_eq("same_cycle_nut_d", {16'd0, nut_d}, 32'd100);
    do_cyc();
    check_eq("nut_d_applied", {16'd0, nut_d}, 32'd7);

    check_eq("rxd_total", rxd_cnt, exp_rxd);
    check_eq("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
